// File: rtl/sw_pkg.sv
// Shared types and constants for the search-window column loader.
package sw_pkg;

   localparam int SW_ROWS   = 88;
   localparam int SW_BYTES  = 352;
   localparam int SW_WORD_W = 32;
   localparam int SW_ADDR_W = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } sw_state_e;

   // One issue slot travelling alongside its memory read.
   typedef struct packed {
      logic                 vld;
      logic                 pad;
      logic [SW_ADDR_W-1:0] row;
   } sw_slot_t;

endpackage

// File: rtl/sw_lat_pipe.sv
// Delay line that keeps each issued row's valid/pad/index aligned with the
// memory read data that returns LAT cycles later.
module sw_lat_pipe
   import sw_pkg::*;
#(
   parameter int LAT = 1
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  sw_slot_t slot_i,
   output sw_slot_t slot_o
);

   sw_slot_t pipe_q [LAT];

   // Shift the slot descriptors one stage per cycle; reset drops in-flight returns.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < LAT; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= slot_i;
         for (int i = 1; i < LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign slot_o = pipe_q[LAT-1];

endmodule

// File: rtl/sw_col_loader.sv
// Loads one ROWS-word column strip from frame memory into the search-window register file.
// Optional SW_LDR_PAD_EN: rows at or beyond frame_rows replicate the last valid row.
module sw_col_loader
   import sw_pkg::*;
#(
   parameter int ROWS    = SW_ROWS,
   parameter int MEM_AW  = 18,
   parameter int MEM_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [MEM_AW-1:0]    base_addr,
   input  logic [MEM_AW-1:0]    stride,
   input  logic [8:0]           frame_rows,
   output logic                 mem_rd,
   output logic [MEM_AW-1:0]    mem_addr,
   input  logic [SW_WORD_W-1:0] mem_rdata,
   output logic                 WE,
   output logic [SW_ADDR_W-1:0] AddrIn,
   output logic [SW_WORD_W-1:0] DataIn,
   output logic                 busy,
   output logic                 done
);

   localparam logic [SW_ADDR_W-1:0] LAST_ROW = SW_ADDR_W'(ROWS - 1);

   if (ROWS < 1 || ROWS > (2 ** SW_ADDR_W)) begin : g_bad_rows
      $error("sw_col_loader: ROWS must be in 1..512");
   end
   if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
      $error("sw_col_loader: MEM_LAT must be in 1..4");
   end

   sw_state_e            state_q, state_d;
   logic [MEM_AW-1:0]    run_addr_q, run_addr_d;
   logic [MEM_AW-1:0]    stride_q, stride_d;
   logic [MEM_AW-1:0]    mem_addr_q, mem_addr_d;
   logic [SW_ADDR_W-1:0] issue_q, issue_d;
   logic [SW_ADDR_W-1:0] addr_in_q, addr_in_d;
   logic [SW_WORD_W-1:0] data_in_q, data_in_d;
   logic [SW_WORD_W-1:0] last_word_q, last_word_d;
   logic                 mem_rd_q, mem_rd_d;
   logic                 we_q, we_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   sw_slot_t             slot_q, slot_d;
   sw_slot_t             ret_s;
   logic                 iss_en_s;
   logic                 iss_pad_s;
   logic [SW_ADDR_W-1:0] iss_row_s;
   logic [MEM_AW-1:0]    iss_addr_s;

`ifdef SW_LDR_PAD_EN
   logic [8:0] frame_rows_q, frame_rows_d;
`else
   logic unused_frame_rows;
   assign unused_frame_rows = ^frame_rows;
`endif

   sw_lat_pipe #(.LAT(MEM_LAT)) u_lat_pipe (
      .clk_i  (clk),
      .rst_i  (rst),
      .slot_i (slot_q),
      .slot_o (ret_s)
   );

   // Sequencer, read issue and write-port next-state logic.
   always_comb begin
      state_d     = state_q;
      run_addr_d  = run_addr_q;
      stride_d    = stride_q;
      issue_d     = issue_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      last_word_d = last_word_q;
      iss_en_s    = 1'b0;
      iss_row_s   = issue_q;
      iss_addr_s  = run_addr_q;
`ifdef SW_LDR_PAD_EN
      frame_rows_d = frame_rows_q;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               iss_en_s    = 1'b1;
               iss_row_s   = '0;
               iss_addr_s  = base_addr;
               run_addr_d  = base_addr + stride;
               stride_d    = stride;
               issue_d     = 9'd1;
               busy_d      = 1'b1;
               last_word_d = '0;
`ifdef SW_LDR_PAD_EN
               frame_rows_d = frame_rows;
`endif
               state_d = (ROWS == 1) ? DRAIN : FETCH;
            end else begin
               state_d = IDLE;
            end
         end
         FETCH: begin
            iss_en_s   = 1'b1;
            run_addr_d = run_addr_q + stride_q;
            issue_d    = issue_q + 9'd1;
            if (issue_q == LAST_ROW) begin
               state_d = DRAIN;
            end else begin
               state_d = FETCH;
            end
         end
         DRAIN: begin
            if (we_q && (addr_in_q == LAST_ROW)) begin
               state_d = DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               state_d = DRAIN;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef SW_LDR_PAD_EN
      iss_pad_s = iss_row_s >= ((state_q == IDLE) ? frame_rows : frame_rows_q);
`else
      iss_pad_s = 1'b0;
`endif

      mem_rd_d    = iss_en_s & ~iss_pad_s;
      mem_addr_d  = mem_rd_d ? iss_addr_s : mem_addr_q;
      slot_d.vld  = iss_en_s;
      slot_d.pad  = iss_pad_s;
      slot_d.row  = iss_row_s;

      // Padded slots reuse the most recent real row (zero if none was read).
      we_d      = ret_s.vld;
      addr_in_d = addr_in_q;
      data_in_d = data_in_q;
      if (ret_s.vld) begin
         addr_in_d = ret_s.row;
         if (ret_s.pad) begin
            data_in_d = last_word_q;
         end else begin
            data_in_d   = mem_rdata;
            last_word_d = mem_rdata;
         end
      end else begin
         addr_in_d = addr_in_q;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         run_addr_q  <= '0;
         stride_q    <= '0;
         mem_addr_q  <= '0;
         issue_q     <= '0;
         addr_in_q   <= '0;
         data_in_q   <= '0;
         last_word_q <= '0;
         mem_rd_q    <= 1'b0;
         we_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         slot_q      <= '0;
`ifdef SW_LDR_PAD_EN
         frame_rows_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         run_addr_q  <= run_addr_d;
         stride_q    <= stride_d;
         mem_addr_q  <= mem_addr_d;
         issue_q     <= issue_d;
         addr_in_q   <= addr_in_d;
         data_in_q   <= data_in_d;
         last_word_q <= last_word_d;
         mem_rd_q    <= mem_rd_d;
         we_q        <= we_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         slot_q      <= slot_d;
`ifdef SW_LDR_PAD_EN
         frame_rows_q <= frame_rows_d;
`endif
      end
   end

   assign mem_rd   = mem_rd_q;
   assign mem_addr = mem_addr_q;
   assign WE       = we_q;
   assign AddrIn   = addr_in_q;
   assign DataIn   = data_in_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_sw_col_loader.sv
// Bench for sw_col_loader: two instances (MEM_LAT 1 and 3) share stimulus and are
// checked every cycle against a job-timeline model; honours SW_LDR_PAD_EN.
module tb_sw_col_loader;

   localparam int ROWS = sw_pkg::SW_ROWS;
`ifdef SW_LDR_PAD_EN
   localparam bit PAD_ON = 1'b1;
`else
   localparam bit PAD_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [17:0] base_addr = '0;
   logic [17:0] stride = '0;
   logic [8:0]  frame_rows = 9'd88;

   logic [1:0]        rd_w, we_w, busy_w, done_w;
   logic [1:0][17:0]  addr_w;
   logic [1:0][8:0]   ain_w;
   logic [1:0][31:0]  din_w;
   logic [31:0]       rdata0, rdata1;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;
   logic rst_prev = 1'b1;

   logic        job_act [2];
   int          job_s   [2];
   logic [17:0] job_b   [2];
   logic [17:0] job_st  [2];
   int          job_fr  [2];
   int          rd_cnt  [2];
   int          done_cnt[2];
   int          done_off[2];
   logic [17:0] first_a [2];
   logic [17:0] second_a[2];
   logic [31:0] sw_mem  [0:511];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] memw(input logic [17:0] a);
      return {8'hC3 ^ a[7:0], 6'b0, a[17:16], a[15:8], a[7:0]};
   endfunction

   function automatic logic [17:0] row_addr(input logic [17:0] b, input logic [17:0] s, input int r);
      return b + s * 18'(r);
   endfunction

   function automatic logic is_pad(input int r, input int fr);
      return PAD_ON && (r >= fr);
   endfunction

   function automatic logic [31:0] exp_data(input logic [17:0] b, input logic [17:0] s,
                                            input int fr, input int r);
      if (is_pad(r, fr)) return (fr == 0) ? 32'h0 : memw(row_addr(b, s, fr - 1));
      return memw(row_addr(b, s, r));
   endfunction

   function automatic logic [7:0] sw_byte(input int idx);
      logic [31:0] w;
      w = sw_mem[idx / 4];
      return w[8 * (idx % 4) +: 8];
   endfunction

   // Frame memory models: word = f(address), returned MEM_LAT cycles after mem_rd.
   logic m0_v;
   logic [17:0] m0_a;
   logic [2:0] m1_v;
   logic [2:0][17:0] m1_a;
   always @(posedge clk) begin
      m0_v <= rd_w[0];
      m0_a <= addr_w[0];
      m1_v <= {m1_v[1:0], rd_w[1]};
      m1_a <= {m1_a[1:0], addr_w[1]};
   end
   assign rdata0 = m0_v ? memw(m0_a) : 32'hDEAD_BEEF;
   assign rdata1 = m1_v[2] ? memw(m1_a[2]) : 32'hDEAD_BEEF;

   sw_col_loader #(.ROWS(ROWS), .MEM_AW(18), .MEM_LAT(1)) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stride(stride),
      .frame_rows(frame_rows), .mem_rd(rd_w[0]), .mem_addr(addr_w[0]), .mem_rdata(rdata0),
      .WE(we_w[0]), .AddrIn(ain_w[0]), .DataIn(din_w[0]), .busy(busy_w[0]), .done(done_w[0])
   );

   sw_col_loader #(.ROWS(ROWS), .MEM_AW(18), .MEM_LAT(3)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stride(stride),
      .frame_rows(frame_rows), .mem_rd(rd_w[1]), .mem_addr(addr_w[1]), .mem_rdata(rdata1),
      .WE(we_w[1]), .AddrIn(ain_w[1]), .DataIn(din_w[1]), .busy(busy_w[1]), .done(done_w[1])
   );

   task automatic check(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", name, d, cyc, got, exp);
      end
   endtask

   // Per-cycle comparison: a job accepted in cycle S reads row k in S+1+k,
   // writes row k in S+2+LAT+k, and pulses done in S+ROWS+LAT+2.
   task automatic model_cycle();
      for (int d = 0; d < 2; d++) begin
         int lat;
         int k;
         logic e_rd, e_we, e_busy, e_done;
         lat = (d == 0) ? 1 : 3;
         if (rst_prev) begin
            job_act[d] = 1'b0;
            check("rst_mem_rd", d, rd_w[d], 32'h0);
            check("rst_mem_addr", d, addr_w[d], 32'h0);
            check("rst_we", d, we_w[d], 32'h0);
            check("rst_addrin", d, ain_w[d], 32'h0);
            check("rst_datain", d, din_w[d], 32'h0);
            check("rst_busy", d, busy_w[d], 32'h0);
            check("rst_done", d, done_w[d], 32'h0);
         end else begin
            k = cyc - job_s[d];
            e_busy = job_act[d] && k >= 1 && k <= ROWS + lat + 1;
            e_done = job_act[d] && k == ROWS + lat + 2;
            e_rd   = job_act[d] && k >= 1 && k <= ROWS && !is_pad(k - 1, job_fr[d]);
            e_we   = job_act[d] && k >= lat + 2 && k < lat + 2 + ROWS;
            check("busy", d, busy_w[d], {31'b0, e_busy});
            check("done", d, done_w[d], {31'b0, e_done});
            check("mem_rd", d, rd_w[d], {31'b0, e_rd});
            check("we", d, we_w[d], {31'b0, e_we});
            if (e_rd) check("mem_addr", d, addr_w[d], row_addr(job_b[d], job_st[d], k - 1));
            if (e_we) begin
               check("addrin", d, ain_w[d], k - lat - 2);
               check("datain", d, din_w[d], exp_data(job_b[d], job_st[d], job_fr[d], k - lat - 2));
            end
            if (rd_w[d]) begin
               if (rd_cnt[d] == 0) first_a[d] = addr_w[d];
               if (rd_cnt[d] == 1) second_a[d] = addr_w[d];
               rd_cnt[d]++;
            end
            if (done_w[d]) begin
               done_cnt[d]++;
               done_off[d] = k;
            end
            if (d == 0 && we_w[0]) sw_mem[ain_w[0]] = din_w[0];
         end
         if (start && !rst && (!job_act[d] || (cyc - job_s[d]) >= ROWS + lat + 3)) begin
            job_act[d]  = 1'b1;
            job_s[d]    = cyc;
            job_b[d]    = base_addr;
            job_st[d]   = stride;
            job_fr[d]   = int'(frame_rows);
            rd_cnt[d]   = 0;
            done_cnt[d] = 0;
            done_off[d] = -1;
         end
      end
      rst_prev = rst;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         model_cycle();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic launch(input logic [17:0] b, input logic [17:0] s, input int fr);
      base_addr  = b;
      stride     = s;
      frame_rows = 9'(fr);
      start      = 1'b1;
      step(1);
      start      = 1'b0;
   endtask

   task automatic check_job(input string tag, input int exp_rd);
      for (int d = 0; d < 2; d++) begin
         check({tag, "_done_cnt"}, d, done_cnt[d], 32'd1);
         check({tag, "_done_off"}, d, done_off[d], (d == 0) ? 32'd91 : 32'd93);
         check({tag, "_rd_cnt"}, d, rd_cnt[d], exp_rd);
      end
   endtask

   initial begin
      job_act = '{1'b0, 1'b0};
      job_s   = '{0, 0};
      step(3);
      rst = 1'b0;
      step(2);

      // Basic load; retries while busy and in the done cycle must be ignored.
      launch(18'h00100, 18'h0002C, 88);
      step(9);
      base_addr = 18'h05000;
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(80);
      base_addr = 18'h09000;
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(10);
      check_job("basic", 88);
      for (int d = 0; d < 2; d++) begin
         check("basic_addr0", d, first_a[d], 32'h00100);
         check("basic_addr1", d, second_a[d], 32'h0012C);
      end
      check("byte0", 0, sw_byte(0), 32'h00);
      check("byte1", 0, sw_byte(1), 32'h01);
      check("byte3", 0, sw_byte(3), 32'hC3);
      check("byte4", 0, sw_byte(4), 32'h2C);
      check("byte5", 0, sw_byte(5), 32'h01);
      check("byte7", 0, sw_byte(7), 32'hEF);
      check("byte348", 0, sw_byte(348), 32'hF4);
      check("byte_last", 0, sw_byte(sw_pkg::SW_BYTES - 1), 32'h37);

      // Address wrap modulo 2^18.
      launch(18'h3FFF0, 18'h00010, 88);
      step(100);
      check_job("wrap", 88);
      for (int d = 0; d < 2; d++) begin
         check("wrap_addr0", d, first_a[d], 32'h3FFF0);
         check("wrap_addr1", d, second_a[d], 32'h00000);
      end

      // Reset at cycle 40 of a load, then a clean stride-0 load.
      launch(18'h02000, 18'h00003, 88);
      step(39);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(100);
      for (int d = 0; d < 2; d++) begin
         check("abort_done_cnt", d, done_cnt[d], 32'd0);
         check("abort_rd_cnt", d, rd_cnt[d], 32'd40);
      end
      launch(18'h00077, 18'h00000, 88);
      step(100);
      check_job("stride0", 88);
      for (int d = 0; d < 2; d++) begin
         check("stride0_addr0", d, first_a[d], 32'h00077);
         check("stride0_addr1", d, second_a[d], 32'h00077);
      end

      // Bottom-edge padding (frame_rows ignored unless padding is built in).
      launch(18'h00400, 18'h00040, 80);
      step(100);
      check_job("pad80", PAD_ON ? 80 : 88);
      check("pad80_row85", 0, sw_mem[85], PAD_ON ? 32'h030017C0 : 32'h83001940);
      launch(18'h00400, 18'h00040, 0);
      step(100);
      check_job("pad0", PAD_ON ? 0 : 88);
      check("pad0_row0", 0, sw_mem[0], PAD_ON ? 32'h00000000 : 32'hC3000400);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
